// File: rtl/xor_puf_pkg.sv
// xor_puf_pkg: shared states, LFSR constants and default timing for the XOR PUF sequencer.
package xor_puf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRST, S_SETUP, S_FIRE, S_SAMPLE, S_DONE} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SEED_SUB = 8'h01;
  localparam int DEF_N_BITS = 16;
  localparam int DEF_RST_CYC = 4;
  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int CNT_W = 16;
  localparam int BW = 6;
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/puf_chal_lfsr.sv
// puf_chal_lfsr: 8-bit Fibonacci challenge LFSR with load, step and zero-seed substitution.
module puf_chal_lfsr
  import xor_puf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? ((seed == 8'h00) ? SEED_SUB : seed) : step ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= '0;
    else lfsr_q <= lfsr_d;
  assign q = lfsr_q;
endmodule

// File: rtl/xor_puf_ctrl.sv
// xor_puf_ctrl: sequences reset/setup/launch/sample of a 3-arbiter XOR PUF over an LFSR challenge walk.
// Defining MAJ_VOTE_EN evaluates each challenge three times, shifts in the majority and adds unstable_cnt.
module xor_puf_ctrl
  import xor_puf_pkg::*;
#(
  parameter int N_BITS     = DEF_N_BITS,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        seed,
  input  logic              abort,
  output logic              busy,
  output logic [7:0]        puf_ch,
  output logic              puf_in,
  output logic              puf_rst,
  input  logic              puf_resp,
  output logic [N_BITS-1:0] resp_word,
  output logic              resp_valid,
  input  logic              resp_ready
`ifdef MAJ_VOTE_EN
  , output logic [7:0]      unstable_cnt
`endif
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N_BITS-1:0] word_q, word_d;
  logic sync1_q, sync2_q;
  logic lfsr_load, lfsr_step, take, bit_in;
`ifdef MAJ_VOTE_EN
  logic [1:0] rep_q, rep_d, ones_q, ones_d, tot;
  logic [7:0] unst_q, unst_d;
`endif
  puf_chal_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (seed),
    .q    (puf_ch)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CNT_W'(1);
    bit_d = bit_q;
    word_d = word_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef MAJ_VOTE_EN
    rep_d = rep_q;
    ones_d = ones_q;
    unst_d = unst_q;
    tot = ones_q + {1'b0, sync2_q};
    take = rep_q == 2'd2;
    bit_in = tot[1];
`else
    take = 1'b1;
    bit_in = sync2_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        lfsr_load = 1'b1;
      end
      S_LOAD: begin
        state_d = S_PRST;
        cnt_d = '0;
        bit_d = '0;
        word_d = '0;
`ifdef MAJ_VOTE_EN
        rep_d = '0;
        ones_d = '0;
        unst_d = '0;
`endif
      end
      S_PRST: if (cnt_q == CNT_W'(RST_CYC - 1)) begin
        state_d = S_SETUP;
        cnt_d = '0;
      end
      S_SETUP: if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
        state_d = S_FIRE;
        cnt_d = '0;
      end
      S_FIRE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
        state_d = S_SAMPLE;
        cnt_d = '0;
      end
      S_SAMPLE: begin
        cnt_d = '0;
        state_d = S_PRST;
`ifdef MAJ_VOTE_EN
        rep_d = take ? 2'd0 : rep_q + 2'd1;
        ones_d = take ? 2'd0 : tot;
        unst_d = (take && (tot[1] ^ tot[0]) && unst_q != 8'hFF) ? unst_q + 8'd1 : unst_q;
`endif
        if (take) begin
          word_d = {word_q[N_BITS-2:0], bit_in};
          lfsr_step = 1'b1;
          bit_d = bit_q + BW'(1);
          state_d = (bit_q == BW'(N_BITS - 1)) ? S_DONE : S_PRST;
        end
      end
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort freezes the datapath so a partial word survives for inspection
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      word_d = word_q;
      bit_d = bit_q;
      lfsr_step = 1'b0;
`ifdef MAJ_VOTE_EN
      rep_d = rep_q;
      ones_d = ones_q;
      unst_d = unst_q;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      word_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      word_q <= word_d;
      sync1_q <= puf_resp;
      sync2_q <= sync1_q;
    end
`ifdef MAJ_VOTE_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rep_q <= '0;
      ones_q <= '0;
      unst_q <= '0;
    end else begin
      rep_q <= rep_d;
      ones_q <= ones_d;
      unst_q <= unst_d;
    end
  assign unstable_cnt = unst_q;
`endif
  assign busy = state_q != S_IDLE;
  assign puf_in = state_q == S_FIRE || state_q == S_SAMPLE;
  assign puf_rst = state_q == S_PRST;
  assign resp_valid = state_q == S_DONE;
  assign resp_word = word_q;
endmodule

// File: tb/tb_xor_puf_ctrl.sv
// tb_xor_puf_ctrl: directed tests against a cycle-count behavioural model of the PUF sequencer.
module tb_xor_puf_ctrl;
  localparam int N = 16, RC = 4, SC = 4, FC = 16, PER = RC + SC + FC + 1;
`ifdef MAJ_VOTE_EN
  localparam int REP = 3;
`else
  localparam int REP = 1;
`endif
  localparam int TOTAL = 1 + REP * N * PER;
  logic clk = 0, rst = 0, start = 0, abort = 0, resp_ready = 0, puf_resp;
  logic [7:0] seed = 0, puf_ch;
  logic busy, puf_in, puf_rst, resp_valid;
  logic [N-1:0] resp_word;
`ifdef MAJ_VOTE_EN
  logic [7:0] unstable_cnt;
`endif
  int pass_n = 0, total_n = 0, puf_mode = 0;
  int m_mode = 0, m_t = 0, m_unst = 0;
  logic [7:0] m_seed = 0;
  logic [N-1:0] m_word = 0;
  always #5 clk = ~clk;
  xor_puf_ctrl #(.N_BITS(N), .RST_CYC(RC), .SETUP_CYC(SC), .SETTLE_CYC(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .abort(abort), .busy(busy),
    .puf_ch(puf_ch), .puf_in(puf_in), .puf_rst(puf_rst), .puf_resp(puf_resp),
    .resp_word(resp_word), .resp_valid(resp_valid), .resp_ready(resp_ready)
`ifdef MAJ_VOTE_EN
    , .unstable_cnt(unstable_cnt)
`endif
  );
  // k-th challenge of the walk: shift left, feedback = bits 8^6^5^4 (1-based)
  function automatic logic [7:0] chal(input logic [7:0] s, input int k);
    int c;
    c = (s == 0) ? 1 : int'(s);
    for (int i = 0; i < k; i++)
      c = ((c * 2) % 256) + (((c >> 7) ^ (c >> 5) ^ (c >> 4) ^ (c >> 3)) & 1);
    return 8'(c);
  endfunction
  function automatic logic resp_of(input int mode, input logic [7:0] s, input int e);
    return mode == 1 ? ^chal(s, e / REP) : mode == 2 ? (e % 3 != 1) : 1'b1;
  endfunction
  function automatic logic [N-1:0] word_of(input int mode, input logic [7:0] s);
    logic [N-1:0] w;
    int ones;
    w = '0;
    for (int b = 0; b < N; b++) begin
      ones = 0;
      for (int r = 0; r < REP; r++) ones += int'(resp_of(mode, s, b * REP + r));
      w = {w[N-2:0], ones * 2 > REP};
    end
    return w;
  endfunction
  function automatic int unst_of(input int mode, input logic [7:0] s);
    int ones, u;
    u = 0;
    for (int b = 0; b < N; b++) begin
      ones = 0;
      for (int r = 0; r < REP; r++) ones += int'(resp_of(mode, s, b * REP + r));
      if (ones != 0 && ones != REP) u++;
    end
    return u;
  endfunction
  assign puf_resp = puf_mode == 1 ? ^puf_ch : puf_mode == 2 ? (((m_t - 1) / PER) % 3 != 1) : 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_mode <= 0;
      m_t <= 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode <= 1;
        m_t <= 0;
        m_seed <= seed;
        m_word <= word_of(puf_mode, seed);
        m_unst <= unst_of(puf_mode, seed);
      end
    end else if (m_mode == 1) begin
      if (abort) m_mode <= 0;
      else begin
        m_t <= m_t + 1;
        if (m_t + 1 == TOTAL) m_mode <= 2;
      end
    end else if (abort || resp_ready) m_mode <= 0;
  int gap = 0;
  logic prev_in = 0;
  always @(negedge clk) begin
    int k, r;
    logic [11:0] e;
    if (m_mode == 0) chk("idle_outs", {busy, puf_in, puf_rst, resp_valid}, 0);
    else begin
      if (m_mode == 2) begin
        e = {4'b1001, chal(m_seed, N)};
        chk("done_word", resp_word, m_word);
`ifdef MAJ_VOTE_EN
        chk("unstable_cnt", unstable_cnt, m_unst);
`endif
      end else if (m_t == 0) e = {4'b1000, chal(m_seed, 0)};
      else begin
        k = (m_t - 1) / PER;
        r = (m_t - 1) % PER;
        e = {1'b1, r >= RC + SC, r < RC, 1'b0, chal(m_seed, k / REP)};
      end
      chk("run_outs", {busy, puf_in, puf_rst, resp_valid, puf_ch}, e);
    end
    if (puf_in && !prev_in) chk("launch_gap", gap, SC);
    gap = puf_rst ? 0 : gap + 1;
    prev_in = puf_in;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int mode, input logic [7:0] s, input logic [7:0] ch0, input logic [7:0] ch1,
                     input logic [N-1:0] wexp, input bit wchk);
    int n;
    puf_mode = mode;
    seed = s;
    start = 1;
    tick;
    start = 0;
    chk("load_ch", puf_ch, ch0);
    n = 0;
    do begin
      tick;
      n++;
      if (n == 1 + REP * PER) chk("step_ch", puf_ch, ch1);
    end while (!resp_valid && n < TOTAL + 50);
    chk("latency", n, TOTAL);
    if (wchk) chk("word_lit", resp_word, wexp);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick;
    chk("rst_ctl", {busy, puf_in, puf_rst, resp_valid}, 0);
    chk("rst_ch", puf_ch, 0);
    chk("rst_word", resp_word, 0);
    rst = 1;
    tick;
    run(0, 8'h00, 8'h01, 8'h02, 16'hFFFF, 1);
    resp_ready = 1;
    tick;
    resp_ready = 0;
    chk("ack_idle", busy, 0);
    run(1, 8'hA5, 8'hA5, 8'h4A, '0, 0);
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      tick;
    end
    start = 0;
    chk("hold_valid", resp_valid, 1);
    chk("hold_word", resp_word, word_of(1, 8'hA5));
    resp_ready = 1;
    tick;
    resp_ready = 0;
    chk("ack_busy", busy, 0);
    chk("ack_valid", resp_valid, 0);
    puf_mode = 0;
    seed = 8'h11;
    start = 1;
    tick;
    start = 0;
    repeat (12) tick;
    chk("pre_rst_fire", puf_in, 1);
    rst = 0;
    #1;
    chk("async_rst", {busy, puf_in, puf_rst, resp_valid}, 0);
    tick;
    rst = 1;
    tick;
    chk("post_rst_busy", busy, 0);
    puf_mode = 1;
    seed = 8'h3C;
    start = 1;
    tick;
    start = 0;
    repeat (99) tick;
    chk("pre_abort_fire", puf_in, 1);
    abort = 1;
    tick;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in", puf_in, 0);
    run(1, 8'h3C, 8'h3C, 8'h79, '0, 0);
    chk("abort_word", resp_word, word_of(1, 8'h3C));
    resp_ready = 1;
    tick;
    resp_ready = 0;
`ifdef MAJ_VOTE_EN
    run(2, 8'h01, 8'h01, 8'h02, 16'hFFFF, 1);
    chk("maj_unstable", unstable_cnt, 16);
    resp_ready = 1;
    tick;
    resp_ready = 0;
`endif
    tick;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/xor_puf_ctrl.md
Name: xor_puf_ctrl

Overview:
Sequencer for the 3-arbiter XOR PUF datapath. On a start request it walks an 8-bit LFSR challenge sequence. For each challenge it resets the arbiters, applies the challenge, fires the launch edge, waits for settling, then samples the synchronized XOR response. It packs N_BITS response bits into one word, which is returned over a valid/ready handshake. The block sits between the system/UART front-end and the XOR PUF instance, and owns that instance's PUF_In, CH and rst pins.

Parameters:
N_BITS, 16, response bits per request (2..32)
RST_CYC, 4, cycles puf_rst held high per evaluation (>=1)
SETUP_CYC, 4, cycles challenge held stable before launch (>=1)
SETTLE_CYC, 16, cycles after launch before sampling (>=3, covers 2-flop synchronizer)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  request pulse; accepted only in IDLE
seed  in  8  LFSR seed, latched on accepted start; 8'h00 is replaced by 8'h01
abort  in  1  return to IDLE next cycle from any non-IDLE state
busy  out  1  high in every state except IDLE
puf_ch  out  8  challenge to the PUF CH bus
puf_in  out  1  launch signal to the PUF PUF_In
puf_rst  out  1  arbiter reset to the PUF rst
puf_resp  in  1  XOR_PUF_Out; asynchronous, 2-flop synchronized internally
resp_word  out  N_BITS  collected response; first sampled bit ends in the MSB
resp_valid  out  1  response word available
resp_ready  in  1  consumer accepts resp_word

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs, counters and both synchronizer flops. State goes to IDLE.
- States: IDLE, LOAD, PRST, SETUP, FIRE, SAMPLE, DONE.
- IDLE: on start=1 go to LOAD. busy=0.
- LOAD (1 cycle): latch the seed into the LFSR and drive puf_ch with it. Clear resp_word and bit_cnt. Go to PRST.
- PRST: puf_rst=1 and puf_in=0 for RST_CYC cycles. Then go to SETUP.
- SETUP: puf_rst=0 and puf_in=0, puf_ch stable, for SETUP_CYC cycles. Then go to FIRE.
- FIRE: puf_in=1 for SETTLE_CYC cycles. Then go to SAMPLE.
- SAMPLE (1 cycle; puf_in stays 1):
  - resp_word <= {resp_word[N_BITS-2:0], sync_resp}.
  - Step the LFSR: Fibonacci, taps 8,6,5,4, shift left, new bit into LSB. puf_ch takes the new value next cycle.
  - bit_cnt++. If bit_cnt reaches N_BITS go to DONE, else go to PRST.
- Cost per bit is RST_CYC+SETUP_CYC+SETTLE_CYC+1 cycles (25 with defaults). resp_valid rises 1+N_BITS*25 = 401 cycles after the accepted start with defaults.
- DONE: resp_valid=1 and resp_word held stable until resp_ready=1 is seen on a clock edge. On that edge go to IDLE, and resp_valid drops the next cycle.
- Handshake: resp_valid is never withdrawn without resp_ready. resp_ready outside DONE is ignored.
- start is ignored outside IDLE, including in DONE.
- abort:
  - Has priority over every transition.
  - Next state is IDLE with puf_in=0, puf_rst=0, resp_valid=0. resp_word is not cleared.
  - abort in IDLE is a no-op.
  - abort and start together in IDLE: start wins.
- LFSR never holds zero: the seed is substituted, and the taps are maximal-length with period 255.
- puf_in rises only in FIRE after at least SETUP_CYC stable challenge cycles. This guarantees a clean race edge.

Optional Feature:
MAJ_VOTE_EN
- Defined:
  - Each challenge is evaluated 3 times; PRST/SETUP/FIRE/SAMPLE repeat with the LFSR held.
  - The majority of the 3 samples is shifted in, and the LFSR steps only after the third sample.
  - An extra output, unstable_cnt [7:0], counts challenges whose 3 samples disagreed. It saturates at 255 and clears in LOAD.
  - Latency becomes 1+3*N_BITS*25.
- Undefined: single evaluation per bit, no unstable_cnt port.

Decomposition:
- Package xor_puf_pkg holds:
  - state enum typedef;
  - LFSR tap mask constant 8'hB8;
  - seed-substitute constant 8'h01;
  - default timing constants.
- One natural sub-module, puf_chal_lfsr: 8-bit LFSR with load, step and zero-seed substitution, instantiated by xor_puf_ctrl.

Test Plan:
- Reset mid-FIRE (rst low for 1 cycle) -> busy, puf_in, puf_rst and resp_valid all 0 immediately; state IDLE.
- Drive puf_resp=1 constantly, start with seed=8'h00 -> puf_ch first shows 8'h01; resp_valid rises at cycle 401; resp_word=16'hFFFF.
- Behavioural PUF model returning parity(puf_ch), seed=8'hA5 -> resp_word matches the reference-model LFSR/parity sequence. Check puf_in rises exactly SETUP_CYC cycles after puf_rst falls, every bit.
- Hold resp_ready=0 for 50 cycles in DONE, pulse start -> resp_valid and resp_word stable, start ignored; resp_ready=1 -> IDLE next cycle.
- abort in cycle 100 -> IDLE next cycle, puf_in=0; a new start then produces a full, correct word.
- MAJ_VOTE_EN with puf_resp toggling 1,0,1 per sample triple -> bit=1, unstable_cnt increments each bit, resp_valid at cycle 1201.
